// File: rtl/mem_arb_guard.sv
// Two-requester shared-memory arbiter: round-robin tie-break, protected address
// window, illegal-command rejection, ack timeout and a saturating violation count.
module mem_arb_guard #(
  parameter logic [31:0] PROT_LO    = 32'h0,
  parameter logic [31:0] PROT_HI    = 32'h4,
  parameter bit          PROT_RD_OK = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        memwrite0,
  input  logic        memwrite1,
  input  logic        memread0,
  input  logic        memread1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic [7:0]  viol_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DENY, FIN} state_t;

  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] WIN_SPAN    = PROT_HI - PROT_LO;

  state_t      state, state_nxt;
  logic        last;
  logic        own_rd, own_wr, own_viol;
  logic [7:0]  wait_cnt;

  logic        any_req, win;
  logic [31:0] sel_addr;
  logic        sel_rd, sel_wr;
  logic        illegal, in_win, viol, timeout;

  logic [1:0]  gnt_nxt, done_nxt, err_nxt;
  logic        rd_nxt, wr_nxt;

  // Winner is requester 1 when it asks alone, or on a tie when 0 went last.
  assign any_req  = req0 | req1;
  assign win      = (req0 & req1) ? ~last : req1;
  assign sel_addr = win ? addr1 : addr0;
  assign sel_rd   = win ? memread1 : memread0;
  assign sel_wr   = win ? memwrite1 : memwrite0;

  // Offset compare handles any window placement without a constant-bound test.
  assign illegal  = (sel_rd == sel_wr);
  assign in_win   = (sel_addr - PROT_LO) <= WIN_SPAN;
  assign viol     = in_win & (sel_wr | (sel_rd & ~PROT_RD_OK));
  assign timeout  = (state == ISSUE) & ~mem_ack & (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = (illegal || viol) ? DENY : ISSUE;
      ISSUE:   if (mem_ack) state_nxt = FIN;
               else if (timeout) state_nxt = IDLE;
      DENY:    state_nxt = IDLE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, decided by the current state.
  always_comb begin
    gnt_nxt  = gnt;
    done_nxt = 2'b00;
    err_nxt  = 2'b00;
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    case (state)
      IDLE: gnt_nxt = any_req ? (win ? 2'b10 : 2'b01) : 2'b00;
      ISSUE: begin
        rd_nxt = own_rd & ~timeout;
        wr_nxt = own_wr & ~timeout;
        if (timeout) begin
          err_nxt = gnt;
          gnt_nxt = 2'b00;
        end
      end
      DENY: begin
        err_nxt = gnt;
        gnt_nxt = 2'b00;
      end
      FIN: begin
        done_nxt = gnt;
        gnt_nxt  = 2'b00;
      end
      default: gnt_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 2'b00;
      done      <= 2'b00;
      err       <= 2'b00;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      viol_cnt  <= 8'h0;
      wait_cnt  <= 8'h0;
      last      <= 1'b1;
      own_rd    <= 1'b0;
      own_wr    <= 1'b0;
      own_viol  <= 1'b0;
    end else begin
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_read  <= rd_nxt;
      mem_write <= wr_nxt;
      // The transaction runs from these copies, so requesters may change freely.
      if (state == IDLE && any_req) begin
        mem_addr <= sel_addr;
        own_rd   <= sel_rd;
        own_wr   <= sel_wr;
        own_viol <= ~illegal & viol;
        last     <= win;
        wait_cnt <= 8'h0;
      end
      if (state == ISSUE && !mem_ack && !timeout) wait_cnt <= wait_cnt + 8'd1;
      if (state == DENY && own_viol && viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
    end
  end

endmodule
